// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - Shared types, default special addresses and lane helpers for dmem_latency_model
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } dmem_state_e;

  localparam logic [31:0] DMEM_STDOUT_ADDR = 32'hf000_0000;
  localparam logic [31:0] DMEM_EXIT_ADDR   = 32'hff00_0000;

  // Big-endian lanes: byte offset 0 lives in bits [31:24]; mask bit i covers bits [8i+7:8i].
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    if (size[1]) begin
      case (off)
        2'd0:    m = 4'b1000;
        2'd1:    m = 4'b0100;
        2'd2:    m = 4'b0010;
        default: m = 4'b0001;
      endcase
    end else if (size[0]) begin
      m = (off == 2'd2) ? 4'b0011 : 4'b1100;
    end else begin
      m = 4'b1111;
    end
    return m;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
    if (size[1]) return {4{wd[7:0]}};
    if (size[0]) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] w);
    logic [31:0] r;
    if (size[1]) begin
      case (off)
        2'd0:    r = {24'h0, w[31:24]};
        2'd1:    r = {24'h0, w[23:16]};
        2'd2:    r = {24'h0, w[15:8]};
        default: r = {24'h0, w[7:0]};
      endcase
    end else if (size[0]) begin
      r = (off == 2'd2) ? {16'h0, w[15:0]} : {16'h0, w[31:16]};
    end else begin
      r = w;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_stdout_fifo.sv
// rtl/dmem_stdout_fifo.sv - Character FIFO feeding the stdout stream of dmem_latency_model
module dmem_stdout_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop;

  assign m_tvalid = (count != '0);
  assign m_tdata  = buf_q[rd_ptr];
  assign pop      = m_tvalid && m_tready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign s_tready = (count != (PTR_W+1)'(DEPTH)) || pop;
  assign push     = s_tvalid && s_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= s_tdata;
  end

endmodule

// File: rtl/dmem_latency_model.sv
// rtl/dmem_latency_model.sv - Fixed-latency data memory model with exit and stdout store targets
// Stdout FIFO and STDOUT_ADDR decode are present only when DMEM_STDOUT_EN is defined.
module dmem_latency_model
  import dmem_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] STDOUT_ADDR = DMEM_STDOUT_ADDR,
  parameter logic [31:0] EXIT_ADDR   = DMEM_EXIT_ADDR,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mreq,
  input  logic              write,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] dad,
  input  logic [31:0]       ddt_wr,
  output logic [31:0]       ddt_rd,
  output logic              ackd_n,
  output logic              err,
  output logic              exit_req,
  output logic              stdout_valid,
  output logic [7:0]        stdout_data,
  input  logic              stdout_ready
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  dmem_state_e       state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write, req_bad, req_exit, req_stdout;
  logic [1:0]        req_size;
  logic [31:0]       req_wdata;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  word_idx;
  logic [3:0]        wr_mask;
  logic [31:0]       wr_data;

  logic stdout_hit, space_ok;
  logic in_exit, in_stdout, in_bad, misaligned, out_range;

`ifdef DMEM_STDOUT_EN
  logic fifo_push;

  assign stdout_hit = (dad == ADDR_W'(STDOUT_ADDR));
  assign fifo_push  = (state == ST_ACK) && req_stdout;

  dmem_stdout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_stdout_fifo (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (req_wdata[7:0]),
    .s_tvalid (fifo_push),
    .s_tready (space_ok),
    .m_tdata  (stdout_data),
    .m_tvalid (stdout_valid),
    .m_tready (stdout_ready)
  );
`else
  logic unused_stdout;

  assign stdout_hit    = 1'b0;
  assign space_ok      = 1'b1;
  assign stdout_valid  = 1'b0;
  assign stdout_data   = 8'h00;
  assign unused_stdout = stdout_ready ^ (^STDOUT_ADDR) ^ (^FIFO_DEPTH);
`endif

  // Classify the incoming request once, at the sample edge.
  always_comb begin
    in_exit    = write && (dad == ADDR_W'(EXIT_ADDR));
    in_stdout  = stdout_hit && write && size[1];
    misaligned = ((size == SZ_HALF) && dad[0]) || ((size == SZ_WORD) && (dad[1:0] != 2'b00));
    out_range  = (dad >> (IDX_W + 2)) != '0;
    in_bad     = !in_exit && !in_stdout &&
                 (stdout_hit || (dad == ADDR_W'(EXIT_ADDR)) || misaligned || out_range);
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (mreq) begin
          cnt_nx = WAIT_INIT;
          if (LATENCY == 1 && !(in_stdout && !space_ok)) state_nx = ST_ACK;
          else                                           state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt != 4'd0)                  cnt_nx   = cnt - 4'd1;
        else if (!req_stdout || space_ok) state_nx = ST_ACK;
      end
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      exit_req <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == ST_ACK && req_exit) exit_req <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && mreq) begin
      req_addr   <= dad;
      req_write  <= write;
      req_size   <= size;
      req_wdata  <= ddt_wr;
      req_bad    <= in_bad;
      req_exit   <= in_exit;
      req_stdout <= in_stdout;
    end
  end

  assign word_idx = req_addr[IDX_W+1:2];
  assign wr_mask  = lane_mask(req_size, req_addr[1:0]);
  assign wr_data  = lane_data(req_size, req_wdata);

  // Stores commit at the end of the ack cycle so a reset before then drops them.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_ACK && req_write && !req_bad && !req_exit && !req_stdout) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign ackd_n = (state != ST_ACK);
  assign err    = (state == ST_ACK) && req_bad;
  assign ddt_rd = (state == ST_ACK && !req_write && !req_bad)
                ? lane_extract(req_size, req_addr[1:0], mem[word_idx]) : 32'h0;

endmodule

// File: tb/tb_dmem_latency_model.sv
// tb/tb_dmem_latency_model.sv - Self-checking bench for dmem_latency_model
// Stdout stream steps are compiled in only when DMEM_STDOUT_EN is defined.
module tb_dmem_latency_model;
  import dmem_pkg::*;

  localparam int          LAT      = 3;
  localparam int          DW       = 64;
  localparam int          NBYTES   = 4 * DW;
  localparam logic [31:0] EXIT_A   = 32'hff00_0000;
  localparam logic [31:0] STDOUT_A = 32'hf000_0000;

  logic        clk = 1'b0;
  logic        rst, mreq, write, stdout_ready;
  logic [1:0]  size;
  logic [31:0] dad, ddt_wr, ddt_rd;
  logic        ackd_n, err, exit_req, stdout_valid;
  logic [7:0]  stdout_data;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] ref_mem [NBYTES];
  logic       model_exit = 1'b0;
  logic [7:0] model_q [$];

  always #5 clk = ~clk;

  dmem_latency_model #(
    .ADDR_W      (32),
    .DEPTH_WORDS (DW),
    .LATENCY     (LAT),
    .STDOUT_ADDR (STDOUT_A),
    .EXIT_ADDR   (EXIT_A),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mreq         (mreq),
    .write        (write),
    .size         (size),
    .dad          (dad),
    .ddt_wr       (ddt_wr),
    .ddt_rd       (ddt_rd),
    .ackd_n       (ackd_n),
    .err          (err),
    .exit_req     (exit_req),
    .stdout_valid (stdout_valid),
    .stdout_data  (stdout_data),
    .stdout_ready (stdout_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return sz[1] ? 1 : (sz[0] ? 2 : 4);
  endfunction

  function automatic bit is_push(input logic w, input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_STDOUT_EN
    return w && (size_bytes(sz) == 1) && (a == STDOUT_A);
`else
    return 1'b0 & w & sz[0] & a[0];
`endif
  endfunction

  function automatic bit model_bad(input logic w, input logic [1:0] sz, input logic [31:0] a);
    int nb = size_bytes(sz);
    if (a == EXIT_A) return !w;
`ifdef DMEM_STDOUT_EN
    if (a == STDOUT_A) return !(w && nb == 1);
`endif
    return ((a % nb) != 0) || (a >= NBYTES);
  endfunction

  function automatic logic [31:0] model_word(input int a);
    return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
  endfunction

  // One complete request: model update, drive, bounded wait for ack, then checks.
  task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e);
    logic [31:0] exp_rd;
    logic        exp_e;
    int          nb, lat;
    exp_e  = model_bad(w, sz, a);
    exp_rd = '0;
    nb     = size_bytes(sz);
    if (!exp_e) begin
      if (w && a == EXIT_A)      model_exit = 1'b1;
      else if (is_push(w, sz, a)) model_q.push_back(wd[7:0]);
      else if (w) for (int i = 0; i < nb; i++) ref_mem[a+i] = 8'(wd >> (8*(nb-1-i)));
      else        for (int i = 0; i < nb; i++) exp_rd = (exp_rd << 8) | 32'(ref_mem[a+i]);
    end
    @(negedge clk);
    mreq = 1'b1; write = w; size = sz; dad = a; ddt_wr = wd;
    @(posedge clk);
    #1 mreq = 1'b0;
    lat = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (ackd_n === 1'b0) begin
        lat = n;
        break;
      end
    end
    rd = ddt_rd;
    e  = err;
    chk("latency", 32'(lat), 32'(LAT));
    chk_bit("err", e, exp_e);
    chk("ddt_rd", rd, exp_rd);
    @(negedge clk);
    chk_bit("ack_one_cycle", ackd_n, 1'b1);
    chk("ddt_rd_idle", ddt_rd, 32'h0);
    chk_bit("exit_req", exit_req, model_exit);
  endtask

  initial begin
    logic [31:0] rd, old;
    logic        e, acked;
    logic [1:0]  sz;
    logic [31:0] a;
    rst = 1'b1; mreq = 1'b0; write = 1'b0; size = 2'b00; dad = '0; ddt_wr = '0;
    stdout_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_bit("rst_ackd_n", ackd_n, 1'b1);
    chk_bit("rst_err", err, 1'b0);
    chk("rst_ddt_rd", ddt_rd, 32'h0);
    chk_bit("rst_exit_req", exit_req, 1'b0);
    chk_bit("rst_stdout_valid", stdout_valid, 1'b0);

    for (int i = 0; i < DW; i++) access(1'b1, SZ_WORD, 32'(4*i), $urandom, rd, e);

    access(1'b1, SZ_WORD, 32'h10, 32'h1122_3344, rd, e);
    access(1'b0, SZ_BYTE, 32'h11, 32'h0, rd, e);
    chk("byte_load_0x11", rd, 32'h0000_0022);
    chk_bit("byte_load_0x11_err", e, 1'b0);
    access(1'b0, 2'b11, 32'h12, 32'h0, rd, e);
    chk("byte_load_sz11", rd, 32'h0000_0033);

    access(1'b1, SZ_WORD, 32'h20, 32'h0, rd, e);
    access(1'b1, SZ_HALF, 32'h22, 32'h0000_beef, rd, e);
    access(1'b0, SZ_WORD, 32'h20, 32'h0, rd, e);
    chk("half_over_word", rd, 32'h0000_beef);

    access(1'b0, SZ_WORD, 32'h13, 32'h0, rd, e);
    chk_bit("misaligned_word_err", e, 1'b1);
    chk("misaligned_word_rd", rd, 32'h0);
    access(1'b0, SZ_HALF, 32'h21, 32'h0, rd, e);
    access(1'b0, SZ_BYTE, 32'(NBYTES-1), 32'h0, rd, e);
    access(1'b0, SZ_BYTE, 32'(NBYTES), 32'h0, rd, e);
    chk_bit("out_of_range_err", e, 1'b1);
    access(1'b1, SZ_WORD, 32'(NBYTES), 32'hdead_beef, rd, e);
    access(1'b0, SZ_WORD, 32'(NBYTES-4), 32'h0, rd, e);

`ifdef DMEM_STDOUT_EN
    for (int i = 0; i < 8; i++) access(1'b1, SZ_BYTE, STDOUT_A, 32'(8'h41 + i), rd, e);
    model_q.push_back(8'h49);
    @(negedge clk);
    mreq = 1'b1; write = 1'b1; size = SZ_BYTE; dad = STDOUT_A; ddt_wr = 32'h49;
    @(posedge clk);
    #1 mreq = 1'b0;
    acked = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!ackd_n) acked = 1'b1;
    end
    chk_bit("stdout_full_stall", acked, 1'b0);
    chk_bit("stdout_valid_full", stdout_valid, 1'b1);
    chk("stdout_first_char", 32'(stdout_data), 32'(model_q.pop_front()));
    stdout_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      stdout_ready = 1'b0;
      if (!ackd_n) begin
        acked = 1'b1;
        break;
      end
    end
    chk_bit("stdout_ack_after_pop", acked, 1'b1);
    begin
      logic [7:0] got [$];
      stdout_ready = 1'b1;
      for (int n = 0; n < 20; n++) begin
        if (stdout_valid) got.push_back(stdout_data);
        @(negedge clk);
      end
      stdout_ready = 1'b0;
      chk("stdout_drain_count", 32'(got.size()), 32'(model_q.size()));
      for (int i = 0; i < got.size() && i < model_q.size(); i++)
        chk("stdout_drain_char", 32'(got[i]), 32'(model_q[i]));
      model_q.delete();
    end
    access(1'b1, SZ_WORD, STDOUT_A, 32'h0, rd, e);
    access(1'b0, SZ_BYTE, STDOUT_A, 32'h0, rd, e);
    chk_bit("stdout_load_err", e, 1'b1);
`else
    access(1'b1, SZ_BYTE, STDOUT_A, 32'h41, rd, e);
    chk_bit("stdout_plain_addr_err", e, 1'b1);
    chk_bit("stdout_valid_off", stdout_valid, 1'b0);
    chk("stdout_data_off", 32'(stdout_data), 32'h0);
`endif

    access(1'b1, SZ_BYTE, EXIT_A, 32'h1, rd, e);
    chk_bit("exit_set", exit_req, 1'b1);
    access(1'b0, SZ_WORD, EXIT_A, 32'h0, rd, e);
    chk_bit("exit_load_err", e, 1'b1);

    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 7));
      access(1'($urandom_range(0, 1)), sz, a, $urandom, rd, e);
    end
    chk_bit("exit_sticky", exit_req, 1'b1);

    old = model_word(32'h40);
    @(negedge clk);
    mreq = 1'b1; write = 1'b1; size = SZ_WORD; dad = 32'h40; ddt_wr = ~old;
    @(posedge clk);
    #1 mreq = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    acked = !ackd_n;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (!ackd_n) acked = 1'b1;
      @(negedge clk);
    end
    chk_bit("rst_wait_no_ack", acked, 1'b0);
    chk_bit("rst_clears_exit", exit_req, 1'b0);
    chk_bit("rst_stdout_valid_2", stdout_valid, 1'b0);
    model_exit = 1'b0;
    access(1'b0, SZ_WORD, 32'h40, 32'h0, rd, e);
    chk("rst_store_dropped", rd, old);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
